// File: rtl/run_controller_if.sv
// Run handshake bundle between the host-side run controller and its environment.
//   start       : one-cycle command to begin a run (environment -> controller)
//   ack         : processor done flag, level (environment -> controller)
//   init_out    : processor init / active-high reset (controller -> environment)
//   req         : processor req/start (controller -> environment)
//   busy        : run in progress, start acceptance through FIN
//   done        : one-cycle pulse, run completed normally
//   timeout     : one-cycle pulse, run aborted after TIMEOUT req cycles
//   ack_err     : one-cycle pulse, ack seen while processor should be in reset
//   cycle_count : req-high cycles of the last completed or timed-out run
//   run_count   : completed runs, wraps 255 -> 0
interface run_controller_if #(
  parameter int unsigned CW = 16
);
  logic          start;
  logic          ack;
  logic          init_out;
  logic          req;
  logic          busy;
  logic          done;
  logic          timeout;
  logic          ack_err;
  logic [CW-1:0] cycle_count;
  logic [7:0]    run_count;

  modport master (
    input  start, ack,
    output init_out, req, busy, done, timeout, ack_err, cycle_count, run_count
  );

  modport slave (
    output start, ack,
    input  init_out, req, busy, done, timeout, ack_err, cycle_count, run_count
  );
endinterface

// File: rtl/run_controller.sv
// Host-side initiator for the processor init/req/ack run handshake.
// A start in IDLE holds the processor in init for INIT_CYCLES cycles, waits
// one settle cycle, then raises req and counts cycles until ack or TIMEOUT.
// The outcome is reported as a one-cycle done/timeout/ack_err pulse in FIN.
// Ports:
//   Clk   : system clock, rising edge
//   Reset : asynchronous active-high reset
//   bus   : run_controller_if master modport (see interface for signals)
module run_controller #(
  parameter int unsigned    INIT_CYCLES = 4,
  parameter int unsigned    CW          = 16,
  parameter logic [CW-1:0]  TIMEOUT     = CW'(16'hFFFF)
) (
  input  logic              Clk,
  input  logic              Reset,
  run_controller_if.master  bus
);

  localparam int unsigned IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    SETTLE,
    RUN,
    FIN
  } state_t;

  state_t        state;
  logic [IW-1:0] init_cnt;
  logic [CW-1:0] run_cnt;
  logic          init_level;
  logic          req_level;
  logic          busy_level;
  logic          done_pulse;
  logic          timeout_pulse;
  logic          ack_err_pulse;
  logic [CW-1:0] last_cycles;
  logic [7:0]    runs;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state         <= IDLE;
      init_cnt      <= '0;
      run_cnt       <= '0;
      init_level    <= 1'b0;
      req_level     <= 1'b0;
      busy_level    <= 1'b0;
      done_pulse    <= 1'b0;
      timeout_pulse <= 1'b0;
      ack_err_pulse <= 1'b0;
      last_cycles   <= '0;
      runs          <= '0;
    end else begin
      // Pulses are only ever set on the transition into FIN, so clearing
      // them every cycle makes each one exactly one cycle wide.
      done_pulse    <= 1'b0;
      timeout_pulse <= 1'b0;
      ack_err_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state      <= INIT;
            init_level <= 1'b1;
            busy_level <= 1'b1;
            init_cnt   <= IW'(INIT_CYCLES - 1);
          end
        end
        INIT: begin
          if (init_cnt == '0) begin
            state      <= SETTLE;
            init_level <= 1'b0;
          end else begin
            init_cnt <= init_cnt - 1'b1;
          end
        end
        SETTLE: begin
          // ack still high after init means the processor did not clear it.
          if (bus.ack) begin
            state         <= FIN;
            ack_err_pulse <= 1'b1;
          end else begin
            state     <= RUN;
            req_level <= 1'b1;
            run_cnt   <= CW'(1);
          end
        end
        RUN: begin
          // ack is tested first so it wins over a simultaneous timeout.
          if (bus.ack) begin
            state       <= FIN;
            req_level   <= 1'b0;
            done_pulse  <= 1'b1;
            last_cycles <= run_cnt;
            runs        <= runs + 8'd1;
          end else if (run_cnt == TIMEOUT) begin
            state         <= FIN;
            req_level     <= 1'b0;
            timeout_pulse <= 1'b1;
            last_cycles   <= TIMEOUT;
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
        end
        FIN: begin
          state      <= IDLE;
          busy_level <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          init_level <= 1'b0;
          req_level  <= 1'b0;
          busy_level <= 1'b0;
        end
      endcase
    end
  end

  assign bus.init_out    = init_level;
  assign bus.req         = req_level;
  assign bus.busy        = busy_level;
  assign bus.done        = done_pulse;
  assign bus.timeout     = timeout_pulse;
  assign bus.ack_err     = ack_err_pulse;
  assign bus.cycle_count = last_cycles;
  assign bus.run_count   = runs;

endmodule

// File: tb/tb_run_controller.sv
module tb_run_controller;
  localparam int INIT_CYC = 4;
  localparam int CW       = 16;
  localparam int TO       = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  run_controller_if #(.CW(CW)) bus ();

  run_controller #(
    .INIT_CYCLES(INIT_CYC),
    .CW         (CW),
    .TIMEOUT    (16'd10)
  ) dut (
    .Clk  (clk),
    .Reset(rst),
    .bus  (bus.master)
  );

  int checks = 0;
  int errors = 0;
  logic [CW-1:0] exp_cc = '0;
  logic [7:0]    exp_rc = '0;

  task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s (cycle %0d): observed %0d, expected %0d", tag, k, obs, exp);
    end
  endtask

  task automatic check_outs(input int k, input bit ei, input bit er, input bit eb,
                            input bit ed, input bit et, input bit ee);
    check("init_out", k, 32'(bus.init_out), 32'(ei));
    check("req",      k, 32'(bus.req),      32'(er));
    check("busy",     k, 32'(bus.busy),     32'(eb));
    check("done",     k, 32'(bus.done),     32'(ed));
    check("timeout",  k, 32'(bus.timeout),  32'(et));
    check("ack_err",  k, 32'(bus.ack_err),  32'(ee));
  endtask

  task automatic check_counts(input int k);
    check("cycle_count", k, 32'(bus.cycle_count), 32'(exp_cc));
    check("run_count",   k, 32'(bus.run_count),   32'(exp_rc));
  endtask

  // One run seen from the host. Cycle k=1 is the first cycle after the edge
  // that accepts start. stuck: ack held high through SETTLE. Otherwise ack
  // is random during init, low in SETTLE and rises on req cycle n (n > TO
  // means it never rises before the limit).
  task automatic do_run(input bit stuck, input int n, input bit noise);
    int len;
    int fin;
    bit ok;
    ok  = !stuck && (n <= TO);
    len = (n <= TO) ? n : TO;
    fin = stuck ? INIT_CYC + 2 : INIT_CYC + 2 + len;
    @(negedge clk);
    bus.start = 1'b1;
    if (stuck) bus.ack = 1'b1;
    for (int k = 1; k <= fin + 1; k++) begin
      @(negedge clk);
      check_outs(k,
                 k <= INIT_CYC,
                 !stuck && k >= INIT_CYC + 2 && k <= INIT_CYC + 1 + len,
                 k <= fin,
                 ok && k == fin,
                 !stuck && n > TO && k == fin,
                 stuck && k == fin);
      bus.start = (noise && k <= fin) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (!stuck) begin
        if (k <= INIT_CYC)          bus.ack = 1'($urandom_range(0, 1));
        else if (k == INIT_CYC + 1) bus.ack = 1'b0;
        else if (k <= fin)          bus.ack = (k - (INIT_CYC + 1) >= n);
      end
      if (k == fin) begin
        if (!stuck) exp_cc = CW'(len);
        if (ok)     exp_rc = exp_rc + 8'd1;
      end
    end
    check_counts(fin + 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.ack   = 1'b0;
    repeat (3) @(negedge clk);
    check_outs(0, 0, 0, 0, 0, 0, 0);
    check_counts(0);
    rst = 1'b0;
    @(negedge clk);
    check_outs(0, 0, 0, 0, 0, 0, 0);

    do_run(1'b0, 5, 1'b0);        // done on 5th req cycle
    do_run(1'b1, 0, 1'b0);        // ack stuck at SETTLE
    do_run(1'b0, TO + 5, 1'b0);   // never acked: timeout
    do_run(1'b0, TO, 1'b0);       // ack exactly at the limit: done wins
    do_run(1'b0, 3, 1'b1);        // start noise throughout the run

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    bus.start = 1'b1;
    bus.ack   = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (INIT_CYC + 3) @(negedge clk);
    check("req_before_reset", 0, 32'(bus.req), 32'd1);
    #2 rst = 1'b1;
    #1;
    exp_cc = '0;
    exp_rc = '0;
    check_outs(0, 0, 0, 0, 0, 0, 0);
    check_counts(0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_outs(0, 0, 0, 0, 0, 0, 0);
    end
    do_run(1'b0, 4, 1'b0);

    // 255 more completed runs bring run_count through 255 back to 0.
    for (int r = 0; r < 255; r++)
      do_run(1'b0, int'($urandom_range(1, TO)), 1'($urandom_range(0, 1)));
    check("run_count_wrap", 0, 32'(bus.run_count), 32'd0);

    for (int r = 0; r < 40; r++)
      do_run($urandom_range(0, 7) == 0, int'($urandom_range(1, TO + 3)), 1'($urandom_range(0, 1)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
